branch_compare_pipe: RTL

BRANCH_COMPARE_PIPE -- requirements
Module: branch_compare_pipe

---
 rtl/branch_compare_pipe.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/branch_compare_pipe.sv
// branch_compare_pipe: two-stage valid/ready branch comparator (EQ/NE/LT/GE/LTU/GEU).
// Optional saturating match counter on match_count, enabled by defining BRANCH_CMP_STATS_EN.
module branch_compare_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             zero,
  output logic             err,
  output logic [15:0]      match_count
);

  typedef enum logic [2:0] {
    OP_EQ  = 3'b000,
    OP_NE  = 3'b001,
    OP_LT  = 3'b010,
    OP_GE  = 3'b011,
    OP_LTU = 3'b100,
    OP_GEU = 3'b101
  } cmp_op_e;

  // Stage 1: registered operands and op.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_rd1;
  logic [WIDTH-1:0] s1_rd2;
  logic [2:0]       s1_op;

  // Stage 2: registered compare outcome.
  logic s2_valid;
  logic s2_result;
  logic s2_zero;
  logic s2_err;

  // Handshake / flow control.
  logic s1_advance;
  logic s1_load;
  logic s2_load;

  // Stage 1 moves forward whenever stage 2 is empty or is draining this cycle.
  assign s1_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign s1_load    = in_valid && in_ready;
  assign s2_load    = s1_valid && s1_advance;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_ready)   s1_valid <= in_valid;
      if (s1_advance) s2_valid <= s1_valid;
    end
  end

  // NOTE: operand registers carry no reset; s1_valid alone qualifies them, so reset cost is avoided.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_rd1 <= rd1;
      s1_rd2 <= rd2;
      s1_op  <= op;
    end
  end

  // Compare logic between the two stages.
  logic cmp_result;
  logic cmp_zero;
  logic cmp_err;
  logic lt_signed;
  logic lt_unsigned;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    cmp_result  = 1'b0;
    cmp_err     = 1'b0;
    cmp_zero    = (s1_rd1 == s1_rd2);
    lt_signed   = ($signed(s1_rd1) < $signed(s1_rd2));
    lt_unsigned = (s1_rd1 < s1_rd2);
    case (s1_op)
      OP_EQ:   cmp_result = cmp_zero;
      OP_NE:   cmp_result = !cmp_zero;
      OP_LT:   cmp_result = lt_signed;
      OP_GE:   cmp_result = !lt_signed;
      OP_LTU:  cmp_result = lt_unsigned;
      OP_GEU:  cmp_result = !lt_unsigned;
      default: cmp_err    = 1'b1;
    endcase
  end

  // Result flops are reset so outputs read 0 while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_result <= 1'b0;
      s2_zero   <= 1'b0;
      s2_err    <= 1'b0;
    end else if (s2_load) begin
      s2_result <= cmp_result;
      s2_zero   <= cmp_zero;
      s2_err    <= cmp_err;
    end
  end

  assign out_valid = s2_valid;
  assign result    = s2_result;
  assign zero      = s2_zero;
  assign err       = s2_err;

`ifdef BRANCH_CMP_STATS_EN
  logic [15:0] stat_count;
  logic        stat_hit;

  assign stat_hit = out_valid && out_ready && s2_result && !s2_err;

  // Saturates at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_count <= 16'd0;
    end else if (stat_hit && (stat_count != 16'hFFFF)) begin
      stat_count <= stat_count + 16'd1;
    end
  end

  assign match_count = stat_count;
`else
  assign match_count = 16'd0;
`endif

  // Protocol properties: a stalled result holds, and a full stalled pipe refuses input.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable({result, zero, err})));

  a_full_stall: assert property (@(posedge clk) disable iff (!rst_n)
    (s1_valid && s2_valid && !out_ready) |-> !in_ready);

endmodule
